// File: rtl/f_matrix_gen.sv
// Kalman state-transition matrix generator: coef[k] = dt^k/k! on one shared
// double multiplier, published atomically into F. Optional macro: FMAT_DT_CACHE_EN.

// IEEE-754 double multiplier, one operation in flight, vld_pipe_q tracks stages.
// Denormals flush to zero; round-to-nearest-even.
module f_matrix_fp_mul (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        ready,
  output logic        finish,
  output logic [63:0] result
);
  localparam int STAGES = 2;

  logic [STAGES:0]    vld_pipe_q, vld_pipe_d;
  logic               s0_sign_q, s0_sign_d, s1_sign_q, s1_sign_d;
  logic signed [12:0] s0_exp_q, s0_exp_d, s1_exp_q, s1_exp_d;
  logic [52:0]        s0_ma_q, s0_ma_d, s0_mb_q, s0_mb_d;
  logic [2:0]         s0_cls_q, s0_cls_d, s1_cls_q, s1_cls_d; // {nan, inf, zero}
  logic [105:0]       s1_prod_q, s1_prod_d;
  logic [63:0]        res_q, res_d;

  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, nan_c, inf_c;
  logic               norm, guard, sticky, rnd_up;
  logic [52:0]        mant53;
  logic [53:0]        mant54;
  logic signed [12:0] e_r;
  logic [51:0]        frac;

  assign ready  = ~|vld_pipe_q;
  assign finish = vld_pipe_q[STAGES];
  assign result = res_q;

  always_comb begin
    vld_pipe_d = {vld_pipe_q[STAGES-1:0], valid & ready};
    a_zero = (a[62:52] == 11'd0);
    b_zero = (b[62:52] == 11'd0);
    a_nan  = (a[62:52] == 11'h7FF) && (|a[51:0]);
    b_nan  = (b[62:52] == 11'h7FF) && (|b[51:0]);
    a_inf  = (a[62:52] == 11'h7FF) && !(|a[51:0]);
    b_inf  = (b[62:52] == 11'h7FF) && !(|b[51:0]);
    nan_c  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
    inf_c  = (a_inf | b_inf) & ~nan_c;

    s0_sign_d = s0_sign_q;
    s0_exp_d  = s0_exp_q;
    s0_ma_d   = s0_ma_q;
    s0_mb_d   = s0_mb_q;
    s0_cls_d  = s0_cls_q;
    if (valid && ready) begin
      s0_sign_d = a[63] ^ b[63];
      s0_exp_d  = $signed({2'b00, a[62:52]}) + $signed({2'b00, b[62:52]}) - 13'sd1023;
      s0_ma_d   = {1'b1, a[51:0]};
      s0_mb_d   = {1'b1, b[51:0]};
      s0_cls_d  = {nan_c, inf_c, (a_zero | b_zero) & ~nan_c & ~inf_c};
    end

    s1_sign_d = s1_sign_q;
    s1_exp_d  = s1_exp_q;
    s1_cls_d  = s1_cls_q;
    s1_prod_d = s1_prod_q;
    if (vld_pipe_q[0]) begin
      s1_sign_d = s0_sign_q;
      s1_exp_d  = s0_exp_q;
      s1_cls_d  = s0_cls_q;
      s1_prod_d = 106'(s0_ma_q) * 106'(s0_mb_q);
    end

    // Product of two [1,2) mantissas lies in [1,4): at most one normalising shift.
    norm   = s1_prod_q[105];
    mant53 = norm ? s1_prod_q[105:53] : s1_prod_q[104:52];
    guard  = norm ? s1_prod_q[52] : s1_prod_q[51];
    sticky = norm ? (|s1_prod_q[51:0]) : (|s1_prod_q[50:0]);
    rnd_up = guard & (sticky | mant53[0]);
    mant54 = {1'b0, mant53} + 54'(rnd_up);
    e_r    = s1_exp_q + (norm ? 13'sd1 : 13'sd0) + (mant54[53] ? 13'sd1 : 13'sd0);
    frac   = mant54[53] ? 52'd0 : mant54[51:0];

    res_d = res_q;
    if (vld_pipe_q[1]) begin
      if (s1_cls_q[2])                       res_d = 64'h7FF8000000000000;
      else if (s1_cls_q[1] || e_r >= 13'sd2047) res_d = {s1_sign_q, 11'h7FF, 52'd0};
      else if (s1_cls_q[0] || e_r <= 13'sd0)  res_d = {s1_sign_q, 63'd0};
      else                                   res_d = {s1_sign_q, e_r[10:0], frac};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      s0_sign_q  <= 1'b0;
      s0_exp_q   <= '0;
      s0_ma_q    <= '0;
      s0_mb_q    <= '0;
      s0_cls_q   <= '0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_cls_q   <= '0;
      s1_prod_q  <= '0;
      res_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s0_sign_q  <= s0_sign_d;
      s0_exp_q   <= s0_exp_d;
      s0_ma_q    <= s0_ma_d;
      s0_mb_q    <= s0_mb_d;
      s0_cls_q   <= s0_cls_d;
      s1_sign_q  <= s1_sign_d;
      s1_exp_q   <= s1_exp_d;
      s1_cls_q   <= s1_cls_d;
      s1_prod_q  <= s1_prod_d;
      res_q      <= res_d;
    end
  end
endmodule

module f_matrix_gen #(
  parameter  int AXES    = 3,
  parameter  int ORDER   = 3,
  parameter  int DW      = 64,
  localparam int STATE_N = AXES * (ORDER + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] deltat,
  output logic          busy,
  output logic          done,
  output logic          f_valid,
  output logic [DW-1:0] F [0:STATE_N-1][0:STATE_N-1]
);
  localparam logic [63:0] ONE    = 64'h3FF0000000000000;
  localparam logic [2:0]  K_LAST = 3'(ORDER);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_POW, S_SCALE, S_PUBLISH} state_t;

  state_t      state_q, state_d;
  logic [63:0] dt_q, dt_d, p_q, p_d;
  logic [2:0]  k_q, k_d;
  logic        issued_q, issued_d, done_q, done_d, f_valid_q, f_valid_d;
  logic [63:0] coef_q [0:ORDER];
  logic [63:0] coef_d [0:ORDER];
  logic [63:0] pub_q  [0:ORDER];
  logic [63:0] pub_d  [0:ORDER];

  logic        mul_valid, mul_ready, mul_finish;
  logic [63:0] mul_a, mul_b, mul_result;

  function automatic logic [63:0] recip(input logic [2:0] k);
    case (k)
      3'd3:    recip = 64'h3FC5555555555555;
      3'd4:    recip = 64'h3FA5555555555555;
      3'd5:    recip = 64'h3F81111111111111;
      default: recip = 64'h3FE0000000000000;
    endcase
  endfunction

  f_matrix_fp_mul u_mul (
    .clk    (clk),
    .rst_n  (~rst),
    .valid  (mul_valid),
    .a      (mul_a),
    .b      (mul_b),
    .ready  (mul_ready),
    .finish (mul_finish),
    .result (mul_result)
  );

  always_comb begin
    state_d   = state_q;
    dt_d      = dt_q;
    p_d       = p_q;
    k_d       = k_q;
    issued_d  = issued_q;
    f_valid_d = f_valid_q;
    coef_d    = coef_q;
    pub_d     = pub_q;
    done_d    = 1'b0;
    mul_valid = 1'b0;
    mul_a     = p_q;
    mul_b     = dt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dt_d    = deltat;
          state_d = S_LOAD;
`ifdef FMAT_DT_CACHE_EN
          // Coefficients still match the published dt; just republish.
          if (f_valid_q && deltat == dt_q) state_d = S_PUBLISH;
`endif
        end
      end
      S_LOAD: begin
        coef_d[1] = dt_q;
        p_d       = dt_q;
        k_d       = 3'd2;
        issued_d  = 1'b0;
        state_d   = (ORDER == 1) ? S_PUBLISH : S_POW;
      end
      S_POW, S_SCALE: begin
        if (state_q == S_SCALE) mul_b = recip(k_q);
        if (!issued_q && mul_ready) begin
          mul_valid = 1'b1;
          issued_d  = 1'b1;
        end
        if (issued_q && mul_finish) begin
          issued_d = 1'b0;
          if (state_q == S_POW) begin
            p_d     = mul_result;
            state_d = S_SCALE;
          end else begin
            for (int i = 2; i <= ORDER; i++)
              if (k_q == 3'(i)) coef_d[i] = mul_result;
            if (k_q == K_LAST) state_d = S_PUBLISH;
            else begin
              k_d     = k_q + 3'd1;
              state_d = S_POW;
            end
          end
        end
      end
      S_PUBLISH: begin
        pub_d     = coef_q;
        done_d    = 1'b1;
        f_valid_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      dt_q      <= '0;
      p_q       <= '0;
      k_q       <= 3'd2;
      issued_q  <= 1'b0;
      done_q    <= 1'b0;
      f_valid_q <= 1'b0;
      for (int i = 0; i <= ORDER; i++) begin
        coef_q[i] <= (i == 0) ? ONE : 64'd0;
        pub_q[i]  <= (i == 0) ? ONE : 64'd0;
      end
    end else begin
      state_q   <= state_d;
      dt_q      <= dt_d;
      p_q       <= p_d;
      k_q       <= k_d;
      issued_q  <= issued_d;
      done_q    <= done_d;
      f_valid_q <= f_valid_d;
      coef_q    <= coef_d;
      pub_q     <= pub_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign f_valid = f_valid_q;

  // F is pure routing of the published coefficient registers onto its band diagonals.
  for (genvar i = 0; i < STATE_N; i++) begin : g_row
    for (genvar j = 0; j < STATE_N; j++) begin : g_col
      if (j >= i && ((j - i) % AXES) == 0) begin : g_band
        assign F[i][j] = pub_q[(j - i) / AXES];
      end else begin : g_zero
        assign F[i][j] = '0;
      end
    end
  end
endmodule
